// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, port indices and
// the latched command that is held on the controller bus for a whole grant.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] din;
    logic        byte_op;
    logic        wr_inh;
    logic        rd;
    logic        wr;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: a lone requester always wins; on a tie either the port not
// served last wins (round-robin) or DMA wins outright (fixed priority).
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = PORT_CPU;
    if (req_i == 2'b11) begin
      gnt_o = fixed_i ? PORT_DMA : ~last_i;
    end else if (req_i[1]) begin
      gnt_o = PORT_DMA;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// CPU/DMA arbiter in front of the SRAM controller: one access at a time,
// command latched at grant, an idle cycle after each access, bus timeout.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter bit FIXED_PRI  = 1'b0,
  parameter int TMO_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] p0_addr,
  input  logic [17:0] p1_addr,
  input  logic [15:0] p0_din,
  input  logic [15:0] p1_din,
  input  logic        p0_rd,
  input  logic        p1_rd,
  input  logic        p0_wr,
  input  logic        p1_wr,
  input  logic        p0_byte,
  input  logic        p1_byte,
  input  logic        p0_wr_inh,
  output logic [15:0] p0_dout,
  output logic [15:0] p1_dout,
  output logic        p0_done,
  output logic        p1_done,
  output logic        p0_tmo,
  output logic        p1_tmo,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_byte,
  output logic        mem_wr_inh,
  input  logic [15:0] mem_dout,
  input  logic        mem_done,
  output state_e      dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  // Requester handshake: rd/wr is a level held until the one-cycle pN_done;
  // the command is sampled only in IDLE, so later input changes are ignored.
  state_e      state_q;
  cmd_t        cmd_q;
  cmd_t        cmd_sel;
  logic        win_q;
  logic        last_q;
  logic        gnt;
  logic [7:0]  cnt_q;
  logic [15:0] p0_dout_q;
  logic [15:0] p1_dout_q;
  logic [1:0]  done_q;
  logic [1:0]  tmo_q;
  logic [1:0]  req;

  assign req = {p1_rd | p1_wr, p0_rd | p0_wr};

  rr_arb2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .fixed_i(FIXED_PRI),
    .gnt_o  (gnt)
  );

  // Read takes precedence when a port raises rd and wr together.
  always_comb begin
    cmd_sel = '{addr: p0_addr, din: p0_din, byte_op: p0_byte,
                wr_inh: p0_wr_inh, rd: p0_rd, wr: p0_wr & ~p0_rd};
    if (gnt == PORT_DMA) begin
      cmd_sel = '{addr: p1_addr, din: p1_din, byte_op: p1_byte,
                  wr_inh: 1'b0, rd: p1_rd, wr: p1_wr & ~p1_rd};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      win_q     <= PORT_CPU;
      last_q    <= PORT_DMA;
      cnt_q     <= '0;
      p0_dout_q <= '0;
      p1_dout_q <= '0;
      done_q    <= '0;
      tmo_q     <= '0;
    end else begin
      done_q <= '0;
      tmo_q  <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            cmd_q   <= cmd_sel;
            win_q   <= gnt;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (mem_done) begin
            if (cmd_q.rd) begin
              if (win_q) p1_dout_q <= mem_dout;
              else       p0_dout_q <= mem_dout;
            end
            done_q[win_q] <= 1'b1;
            state_q       <= RELEASE;
          end else if (cnt_q == TMO_LAST) begin
            if (win_q) p1_dout_q <= '0;
            else       p0_dout_q <= '0;
            done_q[win_q] <= 1'b1;
            tmo_q[win_q]  <= 1'b1;
            state_q       <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RELEASE: begin
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rd/wr are gated by state so they fall as soon as the grant ends or reset hits.
  assign mem_rd     = (state_q == GRANT) & cmd_q.rd;
  assign mem_wr     = (state_q == GRANT) & cmd_q.wr;
  assign mem_addr   = cmd_q.addr;
  assign mem_din    = cmd_q.din;
  assign mem_byte   = cmd_q.byte_op;
  assign mem_wr_inh = cmd_q.wr_inh;

  assign p0_dout   = p0_dout_q;
  assign p1_dout   = p1_dout_q;
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p0_tmo    = tmo_q[0];
  assign p1_tmo    = tmo_q[1];
  assign dbg_state = state_q;

endmodule
